ftdi_engine_arb: RTL and testbench

- Parametrised successor of the FTDI FT245-style async FIFO bus engine.
- Drives rd_n/wr_n/data bus timing with cycle counts set by parameters.
- Presents valid/ready byte streams to the core: an rx output stream and a tx input stream.
- Arbitrates read against write with a bounded-burst round-robin, so neither direction starves.

---
 rtl/ftdi_eng_pkg.sv | 22 ++
 rtl/ftdi_flag_sync.sv | 18 +
 rtl/ftdi_engine_arb.sv | 172 +++++++++++++++++
 tb/tb_ftdi_engine_arb.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_eng_pkg.sv
// Shared types and helpers for the FT245-style bus engine: FSM states,
// transfer directions and the phase counter sizing function.
package ftdi_eng_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        BACKOFF
    } eng_state_t;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    // The phase counter runs 0..max_cyc-1, so clog2(max_cyc) bits suffice (at least 1).
    function automatic int phase_width(input int max_cyc);
        return (max_cyc <= 2) ? 1 : $clog2(max_cyc);
    endfunction

endpackage

// File: rtl/ftdi_flag_sync.sv
// Two-flop synchroniser for the asynchronous FTDI status flags.
// Deliberately unreset: the flops settle from the live pins within two clocks.
module ftdi_flag_sync #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o
);

    logic [W-1:0] meta;

    always_ff @(posedge clk_i) begin
        meta   <= async_i;
        sync_o <= meta;
    end

endmodule

// File: rtl/ftdi_engine_arb.sv
// FT245-style async FIFO bus engine with bounded-burst round-robin read/write arbitration.
// Define FTDI_ENGINE_STATS_EN to add the rx_count_o / tx_count_o transfer counters.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | arbitrate rd_req vs wr_req, launch the granted transfer
// RD_STROBE | rd_n_o low, data_i captured on the last low cycle
// WR_SETUP  | data driven with oe high before wr_n_o falls
// WR_STROBE | wr_n_o low with data driven
// WR_HOLD   | wr_n_o high, data still driven for one cycle
// BACKOFF   | strobes high, oe low, lets the flag synchronisers catch up
module ftdi_engine_arb
    import ftdi_eng_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int RD_LOW_CYC   = 2,
    parameter int WR_SETUP_CYC = 1,
    parameter int WR_LOW_CYC   = 4,
    parameter int BACKOFF_CYC  = 2,
    parameter int BURST_LEN    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rxf_n_i,
    output logic              rd_n_o,
    input  logic              txe_n_i,
    output logic              wr_n_o,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_oe_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              busy_o
`ifdef FTDI_ENGINE_STATS_EN
    ,
    output logic [31:0]       rx_count_o,
    output logic [31:0]       tx_count_o
`endif
);

    localparam int MAX_A   = (RD_LOW_CYC > WR_LOW_CYC) ? RD_LOW_CYC : WR_LOW_CYC;
    localparam int MAX_B   = (WR_SETUP_CYC > BACKOFF_CYC) ? WR_SETUP_CYC : BACKOFF_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int PH_W    = phase_width(MAX_CYC);
    localparam int BC_W    = $clog2(BURST_LEN + 1);

    eng_state_t      state;
    logic [PH_W-1:0] phase;
    logic            last_dir;
    logic [BC_W-1:0] burst_cnt;

    logic [1:0] flags_sync;
    logic       rxf, txe, rd_req, wr_req;
    logic       grant_rd, grant_wr, grant_dir;

    ftdi_flag_sync #(.W(2)) u_flag_sync (
        .clk_i   (clk_i),
        .async_i ({rxf_n_i, txe_n_i}),
        .sync_o  (flags_sync)
    );

    assign rxf    = ~flags_sync[1];
    assign txe    = ~flags_sync[0];
    assign rd_req = rxf & ~rx_valid_o;
    assign wr_req = txe & tx_valid_i;

    always_comb begin
        grant_rd  = 1'b0;
        grant_wr  = 1'b0;
        grant_dir = DIR_RD;
        if (state == IDLE) begin
            if (rd_req && wr_req) begin
                // Stay with the current direction until its burst allowance is spent.
                grant_dir = (burst_cnt < BC_W'(BURST_LEN)) ? last_dir : ~last_dir;
                grant_rd  = (grant_dir == DIR_RD);
                grant_wr  = (grant_dir == DIR_WR);
            end else begin
                grant_rd  = rd_req;
                grant_wr  = wr_req;
                grant_dir = wr_req ? DIR_WR : DIR_RD;
            end
        end
    end

    assign tx_ready_o = grant_wr & ~rst_i;
    assign busy_o     = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            phase      <= '0;
            last_dir   <= DIR_RD;
            burst_cnt  <= '0;
            rd_n_o     <= 1'b1;
            wr_n_o     <= 1'b1;
            data_oe_o  <= 1'b0;
            data_o     <= '0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
`ifdef FTDI_ENGINE_STATS_EN
            rx_count_o <= '0;
            tx_count_o <= '0;
`endif
        end else begin
            phase <= phase + 1'b1;
            if (rx_valid_o && rx_ready_i)
                rx_valid_o <= 1'b0;

            case (state)
                IDLE: begin
                    phase <= '0;
                    if (grant_rd || grant_wr) begin
                        last_dir <= grant_dir;
                        if (grant_dir != last_dir)
                            burst_cnt <= BC_W'(1);
                        else if (burst_cnt != BC_W'(BURST_LEN))
                            burst_cnt <= burst_cnt + 1'b1;
                        if (grant_rd) begin
                            state  <= RD_STROBE;
                            rd_n_o <= 1'b0;
                        end else begin
                            state     <= WR_SETUP;
                            data_o    <= tx_data_i;
                            data_oe_o <= 1'b1;
                        end
                    end
                end
                RD_STROBE: if (phase == PH_W'(RD_LOW_CYC - 1)) begin
                    state      <= BACKOFF;
                    phase      <= '0;
                    rd_n_o     <= 1'b1;
                    rx_data_o  <= data_i;
                    rx_valid_o <= 1'b1;
`ifdef FTDI_ENGINE_STATS_EN
                    rx_count_o <= rx_count_o + 1'b1;
`endif
                end
                WR_SETUP: if (phase == PH_W'(WR_SETUP_CYC - 1)) begin
                    state  <= WR_STROBE;
                    phase  <= '0;
                    wr_n_o <= 1'b0;
                end
                WR_STROBE: if (phase == PH_W'(WR_LOW_CYC - 1)) begin
                    state  <= WR_HOLD;
                    phase  <= '0;
                    wr_n_o <= 1'b1;
`ifdef FTDI_ENGINE_STATS_EN
                    tx_count_o <= tx_count_o + 1'b1;
`endif
                end
                WR_HOLD: begin
                    state     <= BACKOFF;
                    phase     <= '0;
                    data_oe_o <= 1'b0;
                end
                BACKOFF: if (phase == PH_W'(BACKOFF_CYC - 1)) begin
                    state <= IDLE;
                    phase <= '0;
                end
                default: begin
                    state <= IDLE;
                    phase <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ftdi_engine_arb.sv
// Directed self-checking bench for ftdi_engine_arb at default parameters.
module tb_ftdi_engine_arb;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       rxf_n_i = 1'b1;
    logic       txe_n_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       rx_ready_i = 1'b1;
    logic       rd_n_o, wr_n_o, data_oe_o, rx_valid_o, tx_ready_o, busy_o;
    logic [7:0] data_o, rx_data_o;
`ifdef FTDI_ENGINE_STATS_EN
    logic [31:0] rx_count_o, tx_count_o;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    bit viol_seen    = 1'b0;

    always #5 clk_i = ~clk_i;

    ftdi_engine_arb dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rxf_n_i    (rxf_n_i),
        .rd_n_o     (rd_n_o),
        .txe_n_i    (txe_n_i),
        .wr_n_o     (wr_n_o),
        .data_i     (data_i),
        .data_o     (data_o),
        .data_oe_o  (data_oe_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .busy_o     (busy_o)
`ifdef FTDI_ENGINE_STATS_EN
        ,
        .rx_count_o (rx_count_o),
        .tx_count_o (tx_count_o)
`endif
    );

    always @(negedge clk_i)
        if (!rst_i && ((!rd_n_o && !wr_n_o) || (data_oe_o && !rd_n_o)))
            viol_seen = 1'b1;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (4) tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; rxf_n_i = 1'b0; txe_n_i = 1'b0; tx_valid_i = 1'b1; tx_data_i = 8'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (rd_n_o !== 1'b1 || wr_n_o !== 1'b1 || data_oe_o !== 1'b0 || tx_ready_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_strobes cyc %0d: rd_n=%b wr_n=%b oe=%b tx_ready=%b, required 1 1 0 0",
                         i, rd_n_o, wr_n_o, data_oe_o, tx_ready_o);
            end
        end
        tests_run++;
        if (rx_valid_o !== 1'b0 || rx_data_o !== 8'h00 || data_o !== 8'h00 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_regs: rx_valid=%b rx_data=%h data_o=%h busy=%b, required 0 00 00 0",
                     rx_valid_o, rx_data_o, data_o, busy_o);
        end
        rxf_n_i = 1'b1; txe_n_i = 1'b1; tx_valid_i = 1'b0;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        bit seen;
        int n;
        rx_ready_i = 1'b1; data_i = 8'h11; rxf_n_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (rd_n_o === 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL rd_start: rd_n never fell within 10 cycles, required a fall");
        end
        tick();
        tests_run++;
        if (rd_n_o !== 1'b0 || rx_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_low_2: rd_n=%b rx_valid=%b, required 0 0", rd_n_o, rx_valid_o);
        end
        data_i = 8'hA5;
        tick();
        tests_run++;
        if (rd_n_o !== 1'b1 || rx_valid_o !== 1'b1 || rx_data_o !== 8'hA5) begin
            tests_failed++;
            $display("FAIL rd_capture: rd_n=%b rx_valid=%b rx_data=%h, required 1 1 a5",
                     rd_n_o, rx_valid_o, rx_data_o);
        end
        data_i = 8'h00;
        tick();
        tests_run++;
        if (rx_valid_o !== 1'b0 || rd_n_o !== 1'b1 || rx_data_o !== 8'hA5) begin
            tests_failed++;
            $display("FAIL rx_valid_pulse: rx_valid=%b rd_n=%b rx_data=%h, required 0 1 a5",
                     rx_valid_o, rd_n_o, rx_data_o);
        end
        n = 2; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rd_n_o === 1'b0) seen = 1'b1;
            else n++;
        end
        tests_run++;
        if (!seen || n != 3) begin
            tests_failed++;
            $display("FAIL rd_gap: seen=%b high cycles=%0d, required fall after 3 high cycles", seen, n);
        end
        rxf_n_i = 1'b1;
        repeat (15) tick();
        tests_run++;
        if (busy_o !== 1'b0 || rd_n_o !== 1'b1 || rx_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_drain: busy=%b rd_n=%b rx_valid=%b, required 0 1 0", busy_o, rd_n_o, rx_valid_o);
        end
    endtask

    task automatic test_single_write();
        int n, bad;
        txe_n_i = 1'b0; tx_data_i = 8'h3C; tx_valid_i = 1'b0;
        repeat (3) tick();
        tx_valid_i = 1'b1;
        #1;
        tests_run++;
        if (tx_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_ready_grant: tx_ready=%b, required 1", tx_ready_o);
        end
        tick();
        tx_valid_i = 1'b0; tx_data_i = 8'hFF;
        #1;
        tests_run++;
        if (data_oe_o !== 1'b1 || data_o !== 8'h3C || wr_n_o !== 1'b1 || tx_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_setup: oe=%b data=%h wr_n=%b tx_ready=%b, required 1 3c 1 0",
                     data_oe_o, data_o, wr_n_o, tx_ready_o);
        end
        tick();
        n = 0; bad = 0;
        while (wr_n_o === 1'b0 && n < 10) begin
            n++;
            if (data_oe_o !== 1'b1 || data_o !== 8'h3C) bad++;
            tick();
        end
        tests_run++;
        if (n != 4 || bad != 0) begin
            tests_failed++;
            $display("FAIL wr_low_cycles: low=%0d bus_errors=%0d, required 4 0", n, bad);
        end
        tests_run++;
        if (wr_n_o !== 1'b1 || data_oe_o !== 1'b1 || data_o !== 8'h3C) begin
            tests_failed++;
            $display("FAIL wr_hold: wr_n=%b oe=%b data=%h, required 1 1 3c", wr_n_o, data_oe_o, data_o);
        end
        tick();
        tests_run++;
        if (data_oe_o !== 1'b0 || wr_n_o !== 1'b1 || busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_backoff: oe=%b wr_n=%b busy=%b, required 0 1 1", data_oe_o, wr_n_o, busy_o);
        end
        txe_n_i = 1'b1;
        repeat (6) tick();
        tests_run++;
        if (busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_drain: busy=%b, required 0", busy_o);
        end
    endtask

    task automatic test_fairness();
        logic [11:0] got;
        logic [11:0] exp_pat;
        int g;
        logic prev_rd, prev_oe;
        exp_pat = 12'b0000_1111_0000;
        got = '0;
        rx_ready_i = 1'b1; rxf_n_i = 1'b0; txe_n_i = 1'b0; tx_valid_i = 1'b1;
        tx_data_i = 8'h42; data_i = 8'h99;
        do_reset();
        viol_seen = 1'b0;
        g = 0; prev_rd = 1'b1; prev_oe = 1'b0;
        for (int i = 0; i < 400 && g < 12; i++) begin
            tick();
            if (prev_rd && !rd_n_o) begin got[g] = 1'b0; g++; end
            if (!prev_oe && data_oe_o && g < 12) begin got[g] = 1'b1; g++; end
            prev_rd = rd_n_o;
            prev_oe = data_oe_o;
        end
        tests_run++;
        if (g != 12) begin
            tests_failed++;
            $display("FAIL fair_count: grants=%0d, required 12", g);
        end
        for (int i = 0; i < 12; i++) begin
            tests_run++;
            if (got[i] !== exp_pat[i]) begin
                tests_failed++;
                $display("FAIL fair_grant[%0d]: got %s, required %s", i,
                         got[i] ? "WR" : "RD", exp_pat[i] ? "WR" : "RD");
            end
        end
        tests_run++;
        if (viol_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL strobe_overlap: violation seen=%b, required 0", viol_seen);
        end
        rxf_n_i = 1'b1; txe_n_i = 1'b1; tx_valid_i = 1'b0;
        do_reset();
        tick();
    endtask

    task automatic test_backpressure();
        bit seen;
        int n;
        rx_ready_i = 1'b0; rxf_n_i = 1'b0; data_i = 8'hC3;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rx_valid_o === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen || rx_data_o !== 8'hC3) begin
            tests_failed++;
            $display("FAIL bp_first: seen=%b rx_data=%h, required 1 c3", seen, rx_data_o);
        end
        data_i = 8'h00; n = 0;
        repeat (20) begin
            tick();
            if (rd_n_o === 1'b0) n++;
        end
        tests_run++;
        if (n != 0 || rx_valid_o !== 1'b1 || rx_data_o !== 8'hC3) begin
            tests_failed++;
            $display("FAIL bp_hold: rd_low=%0d rx_valid=%b rx_data=%h, required 0 1 c3",
                     n, rx_valid_o, rx_data_o);
        end
        rx_ready_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (rd_n_o === 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL bp_resume: rd_n never fell after ready, required a fall");
        end
        rxf_n_i = 1'b1;
        repeat (15) tick();
        tests_run++;
        if (busy_o !== 1'b0 || rx_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_drain: busy=%b rx_valid=%b, required 0 0", busy_o, rx_valid_o);
        end
    endtask

    task automatic test_mid_reset();
        bit seen;
        txe_n_i = 1'b0; tx_valid_i = 1'b1; tx_data_i = 8'h81;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (wr_n_o === 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL mr_strobe_start: wr_n never fell, required a fall");
        end
        tick();
        rst_i = 1'b1;
        #1;
        tests_run++;
        if (tx_ready_o !== 1'b0 || wr_n_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL mr_in_strobe: tx_ready=%b wr_n=%b, required 0 0", tx_ready_o, wr_n_o);
        end
        tick();
        tests_run++;
        if (wr_n_o !== 1'b1 || data_oe_o !== 1'b0 || rd_n_o !== 1'b1 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL mr_release: wr_n=%b oe=%b rd_n=%b busy=%b, required 1 0 1 0",
                     wr_n_o, data_oe_o, rd_n_o, busy_o);
        end
        tx_valid_i = 1'b0; txe_n_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        tests_run++;
        if (busy_o !== 1'b0 || wr_n_o !== 1'b1 || data_oe_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL mr_idle: busy=%b wr_n=%b oe=%b, required 0 1 0", busy_o, wr_n_o, data_oe_o);
        end
`ifdef FTDI_ENGINE_STATS_EN
        tests_run++;
        if (tx_count_o !== 32'd0 || rx_count_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL mr_stats: tx_count=%0d rx_count=%0d, required 0 0", tx_count_o, rx_count_o);
        end
`endif
        txe_n_i = 1'b0; tx_valid_i = 1'b1; tx_data_i = 8'h5E;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (data_oe_o === 1'b1) seen = 1'b1;
        end
        tx_valid_i = 1'b0; txe_n_i = 1'b1;
        tests_run++;
        if (!seen || data_o !== 8'h5E) begin
            tests_failed++;
            $display("FAIL mr_restart: seen=%b data=%h, required 1 5e", seen, data_o);
        end
        repeat (15) tick();
`ifdef FTDI_ENGINE_STATS_EN
        tests_run++;
        if (tx_count_o !== 32'd1) begin
            tests_failed++;
            $display("FAIL mr_stats_after: tx_count=%0d, required 1", tx_count_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_fairness();
        test_backpressure();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
